mem_interface: RTL and testbench
================================

# mem_interface

Memory-side stage of the multi-cycle core, directly downstream of the control FSM: turns its single-cycle memory strobes (instruction-register write, data read, data write) into a registered request/acknowledge bus transaction. It holds the architectural PC, OldPC, instruction register and data register, and raises `stall` so the FSM freezes its state until the bus completes. A bus watchdog halts the core with a sticky error on a hung access.

## Interface

- `XLEN`, 32: data/address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `TIMEOUT`, 16: maximum BUSY cycles allowed per access; must be ≥ 1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ir_write`  in  1  fetch request from the control FSM.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request.
- `adr_src`  in  1  address select: 0 = `pc`, 1 = `result`.
- `pc_write`  in  1  PC update enable.
- `result`  in  XLEN  result bus; next PC and data address.
- `write_data`  in  XLEN  store data (rs2).
- `stall`  out  1  combinational; FSM must hold state and all strobes while it is high.
- `pc`, `old_pc`, `instr`, `data`  out  XLEN  architectural registers.
- `mem_req`, `mem_we`  out  1  registered bus request and write enable.
- `mem_addr`, `mem_wdata`  out  XLEN  registered bus address and write data.
- `mem_ack`  in  1  completion; valid only while `mem_req` = 1.
- `mem_rdata`  in  XLEN  read data, sampled with `mem_ack`.
- `bus_err`  out  1  sticky watchdog error.

## Operation

- `req` = `ir_write | mem_read | mem_write`. Kind precedence: fetch > store > load; the lower-priority strobes are ignored.
- States and transitions:
  - IDLE → BUSY when `req`. At that edge, latch `mem_addr` = (`adr_src` ? `result` : `pc`) with bits [1:0] forced to 0, `mem_wdata` = `write_data`, `mem_we` = (kind == store), clear the watchdog counter.
  - BUSY → IDLE on `mem_ack`.
  - BUSY → ERROR when `TIMEOUT` BUSY cycles elapse without an ack.
  - ERROR is held until reset.
- `mem_req` = 1 exactly in BUSY. `mem_addr`, `mem_wdata` and `mem_we` are stable throughout BUSY.
- `stall` = (`req` & ~(BUSY & `mem_ack`)) | ERROR.
- Register updates at the completing edge (BUSY & `mem_ack`):
  - fetch: `instr` ← `mem_rdata` and `old_pc` ← `pc`.
  - load: `data` ← `mem_rdata`.
  - store: no register update.
- `pc` ← `result` when `pc_write & ~stall`.
  - A fetch with `pc_write` updates `pc` at the same edge `old_pc` captures the old value.
  - A non-memory cycle (`req` = 0) updates `pc` immediately.
- `mem_ack` in IDLE or ERROR is ignored.
- ERROR: `mem_req` = 0, `bus_err` = 1, `stall` = 1; no register changes.

## Timing

- Reset values:
  - `pc` = `old_pc` = `RESET_PC`
  - `instr` = 32'h0000_0013 (NOP)
  - `data` = `mem_addr` = `mem_wdata` = 0
  - `mem_req` = `mem_we` = `bus_err` = 0
  - state IDLE, watchdog counter 0
- Reset asserted mid-access drops `mem_req` immediately (asynchronous) and discards the access.
- Minimum access: the `req` cycle (`stall` = 1), then a BUSY cycle with `mem_ack` (`stall` = 0, capture at its end). That is 2 cycles, so the FSM spends 2 cycles per memory state.
- Each wait cycle without `mem_ack` adds 1 cycle.
- Back-to-back accesses: `mem_req` deasserts for at least one cycle (IDLE) between transactions.
- Watchdog counts BUSY cycles 1..`TIMEOUT`. An ack in cycle `TIMEOUT` completes normally. With no ack by then, ERROR is entered at the end of cycle `TIMEOUT`, and `bus_err` is high the next cycle.
- No combinational path from `mem_ack`/`mem_rdata` to any bus output. `mem_ack` reaches only `stall`.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle → all outputs at reset values before the next edge; `instr` = 32'h0000_0013.
- **Zero-wait fetch:**
  - stimulus: `pc` = 0x100, `ir_write` = `pc_write` = 1, `result` = 0x104; `mem_ack` driven in the first BUSY cycle with `mem_rdata` = 0x00500093.
  - required: `mem_addr` = 0x100; `stall` high 1 cycle.
  - after the completing edge: `instr` = 0x00500093, `old_pc` = 0x100, `pc` = 0x104.
- **Load with 3 wait cycles:**
  - stimulus: `mem_read` = 1, `adr_src` = 1, `result` = 0x203; ack in BUSY cycle 4 with `mem_rdata` = 0xDEADBEEF.
  - required: `mem_addr` = 0x200; `stall` high 4 cycles; `data` = 0xDEADBEEF; `pc` unchanged.
- **Store:**
  - stimulus: `mem_write` = 1, `result` = 0x40, `write_data` = 0x1234.
  - required: `mem_we` = 1, `mem_addr` = 0x40, `mem_wdata` = 0x1234 held through BUSY; `instr`/`data` unchanged.
- **Precedence and idle ack:**
  - `ir_write` = `mem_write` = 1 → fetch performed, `mem_we` = 0.
  - `mem_ack` pulsed in IDLE → no register change.
- **Watchdog:**
  - `TIMEOUT` = 4, no ack → `mem_req` high 4 cycles, then `mem_req` = 0, `bus_err` = 1, `stall` = 1 until reset.
  - Repeat with ack in cycle 4 → normal completion, `bus_err` = 0.

Source files
------------

// File: rtl/mem_interface.sv
// Memory-side stage of the multi-cycle core: turns control-FSM strobes into a
// registered req/ack bus transaction, holds PC/OldPC/IR/DR, and guards the bus with a watchdog.
module mem_interface #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ir_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            adr_src,
    input  logic            pc_write,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] write_data,
    output logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            bus_err
);
    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERROR} state_t;
    typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

    state_t          r_state;
    kind_t           r_kind;
    logic [CW-1:0]   r_wdog;
    logic            r_mem_req;
    logic            r_mem_we;
    logic            r_bus_err;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_old_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_data;

    logic            w_req;
    logic            w_done;
    logic            w_stall;
    kind_t           w_kind;
    logic [XLEN-1:0] w_addr;

    // Fetch outranks store, store outranks load.
    assign w_req   = ir_write | mem_read | mem_write;
    assign w_kind  = ir_write ? K_FETCH : (mem_write ? K_STORE : K_LOAD);
    assign w_addr  = adr_src ? result : r_pc;
    assign w_done  = (r_state == S_BUSY) & mem_ack;
    assign w_stall = (w_req & ~w_done) | (r_state == S_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_kind      <= K_FETCH;
            r_wdog      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pc        <= RESET_PC;
            r_old_pc    <= RESET_PC;
            r_instr     <= NOP;
            r_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state     <= S_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {w_addr[XLEN-1:2], 2'b00};
                        r_mem_wdata <= write_data;
                        r_mem_we    <= (w_kind == K_STORE);
                        r_kind      <= w_kind;
                        r_wdog      <= '0;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        case (r_kind)
                            K_FETCH: begin
                                r_instr  <= mem_rdata;
                                r_old_pc <= r_pc;
                            end
                            K_LOAD:  r_data <= mem_rdata;
                            default: ;
                        endcase
                    end else if (r_wdog == LAST) begin
                        // Hung access: park in ERROR until reset.
                        r_state   <= S_ERROR;
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_ERROR: ;
                default: r_state <= S_ERROR;
            endcase
            if (pc_write && !w_stall)
                r_pc <= result;
        end
    end

    assign stall     = w_stall;
    assign pc        = r_pc;
    assign old_pc    = r_old_pc;
    assign instr     = r_instr;
    assign data      = r_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: directed vector table, randomized ops against a
// transaction-level model, plus reset and watchdog sequences.
module tb_mem_interface;
    localparam int          XLEN    = 32;
    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam int          TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ir_write = 0, mem_read = 0, mem_write = 0, adr_src = 0, pc_write = 0;
    logic [31:0] result = '0, write_data = '0, mem_rdata = '0;
    logic        mem_ack = 0;
    logic        stall, mem_req, mem_we, bus_err;
    logic [31:0] pc, old_pc, instr, data, mem_addr, mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_interface #(.XLEN(XLEN), .RESET_PC(RST_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .adr_src(adr_src), .pc_write(pc_write),
        .result(result), .write_data(write_data), .stall(stall), .pc(pc),
        .old_pc(old_pc), .instr(instr), .data(data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic        ir, rd, wr, adr, pcw;
        logic [31:0] res, wd, rdata;
        int          waits;
        logic [31:0] exp_addr;
        logic        exp_we;
        int          exp_stalls;
        logic [31:0] exp_pc, exp_old, exp_instr, exp_data;
    } vec_t;

    // Architectural state as the model sees it.
    logic [31:0] m_pc, m_old, m_instr, m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_old = RST_PC; m_instr = 32'h13; m_data = '0;
    endtask

    // Transaction-level prediction: what the access does, not how.
    task automatic predict(inout vec_t v);
        logic req;
        req          = v.ir | v.rd | v.wr;
        v.exp_addr   = (v.adr ? v.res : m_pc) & ~32'h3;
        v.exp_we     = !v.ir && v.wr;
        v.exp_stalls = req ? v.waits + 1 : 0;
        if (v.ir) begin
            m_old   = m_pc;
            m_instr = v.rdata;
        end else if (v.rd && !v.wr) begin
            m_data = v.rdata;
        end
        if (v.pcw) m_pc = v.res;
        v.exp_pc = m_pc; v.exp_old = m_old; v.exp_instr = m_instr; v.exp_data = m_data;
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_op(input vec_t v, input string tag);
        int stalls = 0;
        int busy   = 0;
        bit done   = 0;
        ir_write = v.ir; mem_read = v.rd; mem_write = v.wr;
        adr_src = v.adr; pc_write = v.pcw; result = v.res; write_data = v.wd;
        mem_ack = 0;
        for (int cyc = 0; cyc < TIMEOUT + 3 && !done; cyc++) begin
            if (cyc > 0) begin
                busy++;
                chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
                chk({tag, "_mem_addr"}, mem_addr, v.exp_addr);
                chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, v.exp_we});
                chk({tag, "_mem_wdata"}, mem_wdata, v.wd);
                if (busy == v.waits + 1) begin
                    mem_ack   = 1;
                    mem_rdata = v.rdata;
                end
            end
            @(negedge clk);
            if (stall) stalls++;
            else done = 1;
            @(posedge clk); #1;
            mem_ack = 0;
        end
        ir_write = 0; mem_read = 0; mem_write = 0; pc_write = 0;
        chk({tag, "_completed"}, {31'd0, done}, 32'd1);
        chk({tag, "_stall_cycles"}, stalls, v.exp_stalls);
        chk({tag, "_pc"}, pc, v.exp_pc);
        chk({tag, "_old_pc"}, old_pc, v.exp_old);
        chk({tag, "_instr"}, instr, v.exp_instr);
        chk({tag, "_data"}, data, v.exp_data);
        chk({tag, "_req_idle"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_old_pc"}, old_pc, RST_PC);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_data"}, data, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        //          ir rd wr adr pcw res           wd         rdata         w  addr          we stl pc          old         instr         data
        tbl[0] = '{1, 0, 0, 0, 1, 32'h104, 32'h0,    32'h00500093, 0, 32'h100, 0, 1, 32'h104, 32'h100, 32'h00500093, 32'h0};
        tbl[1] = '{0, 1, 0, 1, 0, 32'h203, 32'h0,    32'hDEADBEEF, 3, 32'h200, 0, 4, 32'h104, 32'h100, 32'h00500093, 32'hDEADBEEF};
        tbl[2] = '{0, 0, 1, 1, 0, 32'h40,  32'h1234, 32'h55555555, 1, 32'h40,  1, 2, 32'h104, 32'h100, 32'h00500093, 32'hDEADBEEF};
        tbl[3] = '{1, 0, 1, 0, 1, 32'h108, 32'h9999, 32'h11111111, 0, 32'h104, 0, 1, 32'h108, 32'h104, 32'h11111111, 32'hDEADBEEF};
        tbl[4] = '{0, 0, 0, 0, 1, 32'h200, 32'h0,    32'h0,        0, 32'h0,   0, 0, 32'h200, 32'h104, 32'h11111111, 32'hDEADBEEF};
        tbl[5] = '{0, 1, 1, 1, 0, 32'h7F,  32'hCAFE, 32'h77777777, 2, 32'h7C,  1, 3, 32'h200, 32'h104, 32'h11111111, 32'hDEADBEEF};
        tbl[6] = '{1, 0, 0, 1, 0, 32'h300, 32'h0,    32'hABCD0000, 3, 32'h300, 0, 4, 32'h200, 32'h200, 32'hABCD0000, 32'hDEADBEEF};

        // Asynchronous reset before any clock edge.
        #2 rst = 1;
        #1 chk_reset_state("reset_async");
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 0;
        model_reset();

        for (int i = 0; i < 7; i++) run_op(tbl[i], $sformatf("vec%0d", i));
        m_pc = tbl[6].exp_pc; m_old = tbl[6].exp_old;
        m_instr = tbl[6].exp_instr; m_data = tbl[6].exp_data;

        // Ack while idle must not touch any register.
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("idle_ack_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 mem_ack = 0;
        chk("idle_ack_instr", instr, m_instr);
        chk("idle_ack_data", data, m_data);
        chk("idle_ack_old_pc", old_pc, m_old);
        chk("idle_ack_pc", pc, m_pc);
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rv.ir = 1'($urandom); rv.rd = 1'($urandom); rv.wr = 1'($urandom);
            rv.adr = 1'($urandom); rv.pcw = 1'($urandom);
            rv.res = $urandom; rv.wd = $urandom; rv.rdata = $urandom;
            rv.waits = $urandom_range(0, TIMEOUT - 1);
            predict(rv);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a BUSY access drops the request at once.
        ir_write = 1;
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, mem_req}, 32'd1);
        @(negedge clk); #1 rst = 1;
        #1 chk_reset_state("midrst");
        ir_write = 0;
        @(posedge clk); #1 rst = 0;
        model_reset();
        rv = '{1, 0, 0, 0, 1, 32'h120, 32'h0, 32'h00A00113, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        predict(rv);
        run_op(rv, "post_rst");

        // Watchdog: no ack ever arrives.
        mem_read = 1;
        @(posedge clk); #1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            chk($sformatf("wdog_req_c%0d", k), {31'd0, mem_req}, 32'd1);
            chk($sformatf("wdog_err_c%0d", k), {31'd0, bus_err}, 32'd0);
            @(posedge clk); #1;
        end
        mem_read = 0; pc_write = 1; result = 32'hFFFF_0000; mem_ack = 1;
        for (int k = 0; k < 3; k++) begin
            chk("wdog_err_req", {31'd0, mem_req}, 32'd0);
            chk("wdog_err_flag", {31'd0, bus_err}, 32'd1);
            chk("wdog_err_stall", {31'd0, stall}, 32'd1);
            chk("wdog_err_pc", pc, m_pc);
            chk("wdog_err_data", data, m_data);
            @(posedge clk); #1;
        end
        pc_write = 0; mem_ack = 0;
        @(negedge clk); #2 rst = 1;
        #1 chk_reset_state("wdog_rst");
        chk("wdog_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
